// File: rtl/conv_pkg.sv
// Types and sizing helpers shared by conv_ctrl, the layer scheduler and the bench.
package conv_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_REWIND,
        S_COMP,
        S_DRAIN,
        S_OUT,
        S_DONE,
        S_ABORT
    } conv_ctrl_state_t;

    function automatic int conv_n(input int r, input int c);
        return r * c;
    endfunction

    // N must be at least one pair and must fit the datapath address space.
    function automatic bit conv_n_ok(input int r, input int c, input int add_w);
        int n;
        n = conv_n(r, c);
        return (n >= 1) && (n <= (1 << add_w));
    endfunction

endpackage

// File: rtl/conv_ctrl_if.sv
// Scheduler-facing control/strobe bundle of conv_ctrl.
// With CONV_CTRL_CONT_EN defined the bundle also carries the cont request.
interface conv_ctrl_if #(
    parameter int In_Add_W = 4
) ();

    logic                start;
    logic                abort;
    logic                busy;
    logic                done;
    logic                clk_en;
    logic                clr;
    logic                en_wr;
    logic                wr;
    logic                en_rd;
    logic                en_MAC;
    logic                en_MAC_out;
    logic [In_Add_W-1:0] cnt;

`ifdef CONV_CTRL_CONT_EN
    logic                cont;

    modport master (
        output start, abort, cont,
        input  busy, done, clk_en, clr, en_wr, wr, en_rd, en_MAC, en_MAC_out, cnt
    );

    modport slave (
        input  start, abort, cont,
        output busy, done, clk_en, clr, en_wr, wr, en_rd, en_MAC, en_MAC_out, cnt
    );
`else
    modport master (
        output start, abort,
        input  busy, done, clk_en, clr, en_wr, wr, en_rd, en_MAC, en_MAC_out, cnt
    );

    modport slave (
        input  start, abort,
        output busy, done, clk_en, clr, en_wr, wr, en_rd, en_MAC, en_MAC_out, cnt
    );
`endif

endinterface

// File: rtl/conv_ctrl_cnt.sv
// Loadable up-counter with a terminal-count flag against a runtime terminal value.
module conv_ctrl_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_q,
    output logic         o_tc
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_en) begin
            r_q <= r_q + W'(1);
        end
    end

    assign o_q  = r_q;
    assign o_tc = (r_q == i_term);

endmodule

// File: rtl/conv_ctrl.sv
// Sequencing controller for one conv window: clear, load N pairs, replay through the MAC, latch.
// Optional macro CONV_CTRL_CONT_EN: DONE with bus.cont=1 chains straight into the next window.
module conv_ctrl
    import conv_pkg::*;
#(
    parameter int In_Add_W = 4,
    parameter int R        = 3,
    parameter int C        = 3,
    parameter int MAC_LAT  = 2
) (
    input  logic       clk,
    input  logic       rst,
    conv_ctrl_if.slave bus
);

    localparam int N = conv_n(R, C);
    localparam logic [In_Add_W-1:0] N_TC     = In_Add_W'(N - 1);
    localparam logic [In_Add_W-1:0] DRAIN_TC = In_Add_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    generate
        if (!conv_n_ok(R, C, In_Add_W)) begin : g_bad_n
            $error("conv_ctrl: R*C must lie in 1..2**In_Add_W");
        end
        if ((MAC_LAT < 0) || (MAC_LAT > (1 << In_Add_W))) begin : g_bad_lat
            $error("conv_ctrl: MAC_LAT must lie in 0..2**In_Add_W");
        end
    endgenerate

    conv_ctrl_state_t    r_state;
    conv_ctrl_state_t    w_next;
    logic                r_busy;
    logic                r_done;
    logic                r_clr;
    logic                r_clk_en;
    logic                r_en_wr;
    logic                r_wr;
    logic                r_en_rd;
    logic                r_en_mac;
    logic                r_en_mac_out;
    logic                w_cont;
    logic                w_cnt_run;
    logic                w_cnt_load;
    logic                w_cnt_tc;
    logic [In_Add_W-1:0] w_cnt_q;
    logic [In_Add_W-1:0] w_cnt_term;

`ifdef CONV_CTRL_CONT_EN
    assign w_cont = bus.cont;
`else
    assign w_cont = 1'b0;
`endif

    // One counter times LOAD, COMP and DRAIN; it is parked at 0 everywhere else.
    assign w_cnt_run  = (r_state == S_LOAD) || (r_state == S_COMP) || (r_state == S_DRAIN);
    assign w_cnt_term = (r_state == S_DRAIN) ? DRAIN_TC : N_TC;
    assign w_cnt_load = !w_cnt_run || w_cnt_tc || bus.abort;

    conv_ctrl_cnt #(
        .W(In_Add_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val ('0),
        .i_en       (w_cnt_run),
        .i_term     (w_cnt_term),
        .o_q        (w_cnt_q),
        .o_tc       (w_cnt_tc)
    );

    always_comb begin
        w_next = r_state;
        if ((r_state != S_IDLE) && bus.abort) begin
            w_next = S_ABORT;
        end else begin
            case (r_state)
                S_IDLE:   if (bus.start && !bus.abort) w_next = S_CLR;
                S_CLR:    w_next = S_LOAD;
                S_LOAD:   if (w_cnt_tc) w_next = S_REWIND;
                S_REWIND: w_next = S_COMP;
                S_COMP:   if (w_cnt_tc) w_next = (MAC_LAT == 0) ? S_OUT : S_DRAIN;
                S_DRAIN:  if (w_cnt_tc) w_next = S_OUT;
                S_OUT:    w_next = S_DONE;
                S_DONE:   w_next = w_cont ? S_CLR : S_IDLE;
                S_ABORT:  w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_clr        <= 1'b0;
            r_clk_en     <= 1'b0;
            r_en_wr      <= 1'b0;
            r_wr         <= 1'b0;
            r_en_rd      <= 1'b0;
            r_en_mac     <= 1'b0;
            r_en_mac_out <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_busy       <= (w_next != S_IDLE);
            r_done       <= (w_next == S_DONE);
            r_clr        <= (w_next == S_CLR) || (w_next == S_REWIND) || (w_next == S_ABORT);
            r_clk_en     <= (w_next == S_LOAD) || (w_next == S_COMP);
            r_en_wr      <= (w_next == S_LOAD);
            r_wr         <= (w_next == S_LOAD);
            r_en_rd      <= (w_next == S_COMP);
            r_en_mac     <= (w_next == S_COMP) || (w_next == S_DRAIN);
            r_en_mac_out <= (w_next == S_OUT);
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.clr        = r_clr;
    assign bus.clk_en     = r_clk_en;
    assign bus.en_wr      = r_en_wr;
    assign bus.wr         = r_wr;
    assign bus.en_rd      = r_en_rd;
    assign bus.en_MAC     = r_en_mac;
    assign bus.en_MAC_out = r_en_mac_out;
    assign bus.cnt        = r_clk_en ? w_cnt_q : '0;

endmodule

// File: tb/tb_conv_ctrl.sv
// Scoreboard bench for conv_ctrl: default instance (R=C=3, MAC_LAT=2) plus a minimal one (R=C=1, MAC_LAT=0).
// The cont scenario runs only when CONV_CTRL_CONT_EN is defined.
module tb_conv_ctrl;
    import conv_pkg::*;

    localparam int W = 4;

    typedef struct {
        int t0;
        int done_off;
        int out_off;
        int wr_n;
        int ewr_n;
        int rd_n;
        int mac_n;
        int clr_n;
        int clken_n;
        int busy_n;
        int cnt_sum;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    int a_wr, a_ewr, a_rd, a_mac, a_clr, a_clken, a_busy, a_cnt, a_out;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_ctrl_if #(.In_Add_W(W)) bus  ();
    conv_ctrl_if #(.In_Add_W(W)) bus1 ();

    conv_ctrl #(.In_Add_W(W), .R(3), .C(3), .MAC_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    conv_ctrl #(.In_Add_W(W), .R(1), .C(1), .MAC_LAT(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Nominal default window: N=9, MAC_LAT=2, done 24 cycles after the start edge.
    function automatic exp_t mk(input int t0, input int base);
        exp_t e;
        e.t0       = t0;
        e.done_off = base + 24;
        e.out_off  = base + 23;
        e.wr_n     = 9;
        e.ewr_n    = 9;
        e.rd_n     = 9;
        e.mac_n    = 11;
        e.clr_n    = 2;
        e.clken_n  = 18;
        e.busy_n   = 24;
        e.cnt_sum  = 72;
        return e;
    endfunction

    function automatic int strobes(input int dummy);
        return dummy + int'({bus.done, bus.clk_en, bus.clr, bus.en_wr, bus.wr,
                             bus.en_rd, bus.en_MAC, bus.en_MAC_out, bus.cnt});
    endfunction

    task automatic clear_acc();
        a_wr = 0; a_ewr = 0; a_rd = 0; a_mac = 0; a_clr = 0;
        a_clken = 0; a_busy = 0; a_cnt = 0; a_out = -1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (bus.busy && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(n < budget), 1);
    endtask

    initial begin : monitor
        exp_t e;
        clear_acc();
        forever begin
            @(negedge clk);
            if (rst && bus.busy) begin
                a_busy++;
                a_wr    += int'(bus.wr);
                a_ewr   += int'(bus.en_wr);
                a_rd    += int'(bus.en_rd);
                a_mac   += int'(bus.en_MAC);
                a_clr   += int'(bus.clr);
                a_clken += int'(bus.clk_en);
                a_cnt   += int'(bus.cnt);
                if (bus.en_MAC_out) a_out = cyc;
                if (bus.done) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", int'(bus.done), 0);
                    end else begin
                        e = q.pop_front();
                        $display("txn: done at +%0d wr=%0d rd=%0d mac=%0d clr=%0d busy=%0d cnt_sum=%0d",
                                 cyc - e.t0, a_wr, a_rd, a_mac, a_clr, a_busy, a_cnt);
                        chk("done_latency", cyc - e.t0, e.done_off);
                        chk("mac_out_cycle", a_out - e.t0, e.out_off);
                        chk("wr_cycles", a_wr, e.wr_n);
                        chk("en_wr_cycles", a_ewr, e.ewr_n);
                        chk("en_rd_cycles", a_rd, e.rd_n);
                        chk("en_mac_cycles", a_mac, e.mac_n);
                        chk("clr_cycles", a_clr, e.clr_n);
                        chk("clk_en_cycles", a_clken, e.clken_n);
                        chk("busy_cycles", a_busy, e.busy_n);
                        chk("cnt_sum", a_cnt, e.cnt_sum);
                    end
                    clear_acc();
                end
            end else begin
                if (rst) chk("idle_quiet", strobes(0), 0);
                clear_acc();
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int t0;
        int done_at, mac_n, wr_n, busy_n, clr_n;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
`ifdef CONV_CTRL_CONT_EN
        bus.cont   = 1'b0;
        bus1.cont  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_strobes", strobes(0), 0);
        rst = 1'b1;
        @(negedge clk);

        // Nominal default window
        t0 = cyc;
        q.push_back(mk(t0, 0));
        pulse_start();
        chk("clr_at_cycle1", int'(bus.clr), 1);
        chk("busy_at_cycle1", int'(bus.busy), 1);
        run_until_idle(60);
        repeat (2) @(negedge clk);

        // Minimal window: N=1, no drain
        t0 = cyc;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        done_at = -1; mac_n = 0; wr_n = 0; busy_n = 0; clr_n = 0;
        for (int i = 0; i < 12; i++) begin
            busy_n += int'(bus1.busy);
            mac_n  += int'(bus1.en_MAC);
            wr_n   += int'(bus1.wr);
            clr_n  += int'(bus1.clr);
            if (bus1.done) done_at = cyc - t0;
            @(negedge clk);
        end
        $display("txn: small done at +%0d mac=%0d wr=%0d busy=%0d", done_at, mac_n, wr_n, busy_n);
        chk("small_done_latency", done_at, 6);
        chk("small_en_mac_cycles", mac_n, 1);
        chk("small_wr_cycles", wr_n, 1);
        chk("small_busy_cycles", busy_n, 6);
        chk("small_clr_cycles", clr_n, 2);

        // Abort during COMP
        t0 = cyc;
        pulse_start();
        repeat (14) @(negedge clk);
        chk("comp_en_rd_at15", int'(bus.en_rd), 1);
        chk("comp_cnt_at15", int'(bus.cnt), 3);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        $display("txn: abort at +%0d clr=%0d busy=%0d", cyc - t0, bus.clr, bus.busy);
        chk("abort_clr", int'(bus.clr), 1);
        chk("abort_busy", int'(bus.busy), 1);
        chk("abort_no_mac_out", int'(bus.en_MAC_out), 0);
        chk("abort_cnt", int'(bus.cnt), 0);
        @(negedge clk);
        chk("abort_then_idle", int'(bus.busy), 0);
        repeat (2) @(negedge clk);

        // start and abort together in IDLE: abort wins
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_idle", int'(bus.busy), 0);
        @(negedge clk);

        // Re-pulsed start at 5 and 24 ignored; start at 25 runs a second window
        t0 = cyc;
        q.push_back(mk(t0, 0));
        pulse_start();
        repeat (4) @(negedge clk);
        pulse_start();
        repeat (18) @(negedge clk);
        chk("done_before_repulse", int'(bus.done), 1);
        pulse_start();
        chk("repulse_ignored", int'(bus.busy), 0);
        q.push_back(mk(cyc, 0));
        pulse_start();
        run_until_idle(60);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of COMP
        t0 = cyc;
        pulse_start();
        repeat (12) @(negedge clk);
        rst = 1'b0;
        #1;
        $display("txn: reset at +%0d busy=%0d en_rd=%0d", cyc - t0, bus.busy, bus.en_rd);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_strobes", strobes(0), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        q.push_back(mk(cyc, 0));
        pulse_start();
        run_until_idle(60);
        repeat (2) @(negedge clk);

`ifdef CONV_CTRL_CONT_EN
        // Continuous mode: two back-to-back windows
        bus.cont = 1'b1;
        t0 = cyc;
        q.push_back(mk(t0, 0));
        q.push_back(mk(t0, 24));
        pulse_start();
        repeat (24) @(negedge clk);
        chk("cont_busy_at25", int'(bus.busy), 1);
        chk("cont_clr_at25", int'(bus.clr), 1);
        bus.cont = 1'b0;
        run_until_idle(60);
        repeat (2) @(negedge clk);
`endif

        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
